// File: rtl/loc_step_unit_pkg.sv
// Shared widths and step-direction encodings for the grid-walker location datapath.
package loc_step_unit_pkg;

  localparam int unsigned COORD_W_DEF = 4;

  localparam logic [1:0] DIR_YDEC = 2'b00;
  localparam logic [1:0] DIR_XINC = 2'b01;
  localparam logic [1:0] DIR_XDEC = 2'b10;
  localparam logic [1:0] DIR_YINC = 2'b11;

endpackage

// File: rtl/loc_step_unit_if.sv
// Location bus between the walker FSM (master) and the step datapath (slave).
interface loc_step_unit_if #(
  parameter int unsigned COORD_W = loc_step_unit_pkg::COORD_W_DEF
);

  localparam int unsigned LOC_W = 2 * COORD_W;

  logic             rg_ld;
  logic [1:0]       dir;
  logic [LOC_W-1:0] cur_loc;
  logic [LOC_W-1:0] nxt_loc;
  logic             cnt_reach;
  logic [LOC_W-1:0] loc_q;

  modport master (
    output rg_ld, dir, cur_loc,
    input  nxt_loc, cnt_reach, loc_q
  );

  modport slave (
    input  rg_ld, dir, cur_loc,
    output nxt_loc, cnt_reach, loc_q
  );

endinterface

// File: rtl/loc_step_unit_adder.sv
// COORD_W-bit ripple adder: a + b + ci -> {co, sum}.
module loc_step_unit_adder #(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] a,
  input  logic [COORD_W-1:0] b,
  input  logic               ci,
  output logic [COORD_W-1:0] sum,
  output logic               co
);

  // Widen by one bit so the carry-out falls out of the sum
  always_comb begin
    {co, sum} = {1'b0, a} + {1'b0, b} + (COORD_W+1)'(ci);
  end

endmodule

// File: rtl/loc_step_unit_mux2to1.sv
// COORD_W-bit 2:1 multiplexer, sl=1 selects in1.
module loc_step_unit_mux2to1 #(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] in0,
  input  logic [COORD_W-1:0] in1,
  input  logic               sl,
  output logic [COORD_W-1:0] out
);

  // Plain select
  always_comb begin
    out = sl ? in1 : in0;
  end

endmodule

// File: rtl/loc_step_unit_reg4b.sv
// COORD_W-bit register with asynchronous active-low clear and load enable.
module loc_step_unit_reg4b #(
  parameter int unsigned COORD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [COORD_W-1:0] d,
  output logic [COORD_W-1:0] q
);

  // Clear immediately on reset, otherwise load when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/loc_step_unit.sv
// Grid-walker location datapath: one-step neighbour, edge-wrap flag, and a held location.
module loc_step_unit
  import loc_step_unit_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  loc_step_unit_if.slave bus
);

  logic [COORD_W-1:0] x_cur;
  logic [COORD_W-1:0] y_cur;
  logic [COORD_W-1:0] sel;
  logic [COORD_W-1:0] step;
  logic [COORD_W-1:0] res;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               sl;
  logic               co;

  assign x_cur = bus.cur_loc[2*COORD_W-1:COORD_W];
  assign y_cur = bus.cur_loc[COORD_W-1:0];

  // Odd-parity directions move along x, even-parity along y
  assign sl = bus.dir[1] ^ bus.dir[0];

  // dir[0] picks +1, otherwise -1 as all-ones modulo 2^COORD_W
  assign step = bus.dir[0] ? COORD_W'(1) : {COORD_W{1'b1}};

  loc_step_unit_mux2to1 #(.COORD_W(COORD_W)) u_mux (
    .in0 (y_cur),
    .in1 (x_cur),
    .sl  (sl),
    .out (sel)
  );

  loc_step_unit_adder #(.COORD_W(COORD_W)) u_adder (
    .a   (sel),
    .b   (step),
    .ci  (1'b0),
    .sum (res),
    .co  (co)
  );

  // Rebuild the location with only the stepped axis replaced
  assign bus.nxt_loc = sl ? {res, y_cur} : {x_cur, res};

  // +1 wraps exactly when it carries out; -1 (adding all-ones) wraps exactly when it does not
  assign bus.cnt_reach = co ^ ~bus.dir[0];

  loc_step_unit_reg4b #(.COORD_W(COORD_W)) u_reg_x (
    .clk (clk),
    .rst (rst),
    .ld  (bus.rg_ld),
    .d   (x_cur),
    .q   (x_q)
  );

  loc_step_unit_reg4b #(.COORD_W(COORD_W)) u_reg_y (
    .clk (clk),
    .rst (rst),
    .ld  (bus.rg_ld),
    .d   (y_cur),
    .q   (y_q)
  );

  assign bus.loc_q = {x_q, y_q};

endmodule

// File: tb/tb_loc_step_unit.sv
// Randomised and directed checks of loc_step_unit against a coordinate-arithmetic model.
module tb_loc_step_unit;
  import loc_step_unit_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] model_q;

  loc_step_unit_if #(.COORD_W(4)) bus ();

  loc_step_unit #(.COORD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grid walk model: integer coordinates, step off the grid is flagged then wrapped
  function automatic void model(input logic [7:0] cur, input logic [1:0] d,
                                output logic [7:0] nxt, output logic reach);
    int x;
    int y;
    x = int'(cur[7:4]);
    y = int'(cur[3:0]);
    reach = 1'b0;
    case (d)
      DIR_YDEC: y = y - 1;
      DIR_XINC: x = x + 1;
      DIR_XDEC: x = x - 1;
      default:  y = y + 1;
    endcase
    if (x < 0 || x > 15 || y < 0 || y > 15) reach = 1'b1;
    x = (x + 16) % 16;
    y = (y + 16) % 16;
    nxt = {4'(x), 4'(y)};
  endfunction

  // Drive a combinational case and compare with the model
  task automatic comb_case(input string tag, input logic [7:0] cur, input logic [1:0] d);
    logic [7:0] enxt;
    logic       ereach;
    bus.cur_loc = cur;
    bus.dir     = d;
    #1;
    model(cur, d, enxt, ereach);
    check({tag, "_nxt"}, 32'(bus.nxt_loc), 32'(enxt));
    check({tag, "_reach"}, 32'(bus.cnt_reach), 32'(ereach));
  endtask

  // Directed case with a literal expectation
  task automatic fixed_case(input string tag, input logic [7:0] cur, input logic [1:0] d,
                            input logic [7:0] enxt, input logic ereach);
    bus.cur_loc = cur;
    bus.dir     = d;
    #1;
    check({tag, "_nxt"}, 32'(bus.nxt_loc), 32'(enxt));
    check({tag, "_reach"}, 32'(bus.cnt_reach), 32'(ereach));
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    model_q     = 8'h00;
    rst         = 1'b0;
    bus.rg_ld   = 1'b0;
    bus.dir     = 2'b00;
    bus.cur_loc = 8'h00;

    #2;
    check("reset_q", 32'(bus.loc_q), 32'h00);
    @(negedge clk);
    rst = 1'b1;

    // Interior steps
    fixed_case("int_xinc", 8'h35, 2'b01, 8'h45, 1'b0);
    fixed_case("int_xdec", 8'h35, 2'b10, 8'h25, 1'b0);
    fixed_case("int_yinc", 8'h35, 2'b11, 8'h36, 1'b0);
    fixed_case("int_ydec", 8'h35, 2'b00, 8'h34, 1'b0);
    // Edge wraps
    fixed_case("edge_yinc", 8'h3F, 2'b11, 8'h30, 1'b1);
    fixed_case("edge_ydec", 8'h30, 2'b00, 8'h3F, 1'b1);
    fixed_case("edge_xinc", 8'hF3, 2'b01, 8'h03, 1'b1);
    fixed_case("edge_xdec", 8'h05, 2'b10, 8'hF5, 1'b1);
    // Near edge, no wrap
    fixed_case("near_xinc", 8'hE0, 2'b01, 8'hF0, 1'b0);
    fixed_case("near_ydec", 8'h01, 2'b00, 8'h00, 1'b0);
    check("hold_after_comb", 32'(bus.loc_q), 32'h00);

    // Register load and hold
    @(negedge clk);
    bus.rg_ld   = 1'b1;
    bus.cur_loc = 8'hA7;
    @(posedge clk);
    #1;
    check("load_a7", 32'(bus.loc_q), 32'hA7);
    @(negedge clk);
    bus.rg_ld   = 1'b0;
    bus.cur_loc = 8'h12;
    bus.dir     = DIR_XINC;
    @(posedge clk);
    #1;
    check("hold_a7", 32'(bus.loc_q), 32'hA7);

    // Asynchronous reset between edges
    #1;
    rst = 1'b0;
    #1;
    check("async_clr", 32'(bus.loc_q), 32'h00);
    check("async_nxt", 32'(bus.nxt_loc), 32'h22);
    @(negedge clk);
    bus.rg_ld = 1'b1;
    @(posedge clk);
    #1;
    check("ld_in_reset", 32'(bus.loc_q), 32'h00);
    @(negedge clk);
    rst       = 1'b1;
    bus.rg_ld = 1'b0;
    model_q   = 8'h00;

    // Randomised load/hold traffic with combinational checks
    for (int i = 0; i < 300; i++) begin
      logic [7:0] cur;
      logic [1:0] d;
      logic       ld;
      cur = 8'($urandom);
      d   = 2'($urandom);
      ld  = 1'($urandom_range(0, 1));
      bus.rg_ld = ld;
      comb_case("rand", cur, d);
      if (ld) model_q = cur;
      @(posedge clk);
      #1;
      check("rand_q", 32'(bus.loc_q), 32'(model_q));
      @(negedge clk);
    end

    // Exhaustive sweep of every location and direction
    bus.rg_ld = 1'b0;
    for (int c = 0; c < 256; c++) begin
      for (int d = 0; d < 4; d++) begin
        comb_case("sweep", 8'(c), 2'(d));
        check("sweep_x", 32'($isunknown(bus.nxt_loc)), 32'd0);
      end
    end
    check("sweep_hold", 32'(bus.loc_q), 32'(model_q));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
